// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, RV32I sub-word merge/extend, registered response.
module dmem_responder #(
  parameter int unsigned AddressWidth = 10,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned Latency      = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_wr_i,
  input  logic [31:0]          req_addr_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 rsp_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                r_state;
  logic [3:0]            r_cnt;
  logic                  r_wr;
  logic                  r_err;
  logic [2:0]            r_funct3;
  logic [AddressWidth-1:0] r_idx;
  logic [1:0]            r_lane;
  logic [DataWidth-1:0]  r_wdata;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DataWidth-1:0]  r_rsp_rdata;
  logic [DataWidth-1:0]  r_mem [2**AddressWidth];

  logic                  w_misalign;
  logic                  w_bad_funct3;
  logic                  w_req_err;
  logic                  w_commit;
  logic [DataWidth-1:0]  w_rd_word;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [DataWidth-1:0]  w_load;
  logic [3:0]            w_be;
  logic [DataWidth-1:0]  w_wr_data;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_misalign   = 1'b0;
    w_bad_funct3 = 1'b0;
    if (req_funct3_i[1:0] == 2'd1) w_misalign = req_addr_i[0];
    if (req_funct3_i[1:0] == 2'd2) w_misalign = (req_addr_i[1:0] != 2'b00);
    if (req_wr_i) w_bad_funct3 = (req_funct3_i > 3'd2);
    else          w_bad_funct3 = (req_funct3_i == 3'd3) || (req_funct3_i[2:1] == 2'b11);
    w_req_err = w_misalign || w_bad_funct3 || (|req_addr_i[31:AddressWidth+2]);
  end

  assign w_rd_word = r_mem[r_idx];
  assign w_rd_byte = w_rd_word[{r_lane, 3'b000} +: 8];
  assign w_rd_half = r_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_load = '0;
    case (r_funct3)
      3'd0:    w_load = {{24{w_rd_byte[7]}}, w_rd_byte};
      3'd1:    w_load = {{16{w_rd_half[15]}}, w_rd_half};
      3'd2:    w_load = w_rd_word;
      3'd4:    w_load = {24'h0, w_rd_byte};
      3'd5:    w_load = {16'h0, w_rd_half};
      default: w_load = '0;
    endcase
  end

  // Store data is replicated across lanes; byte enables pick the lanes that change.
  always_comb begin
    w_be      = 4'b1111;
    w_wr_data = r_wdata;
    case (r_funct3[1:0])
      2'd0: begin
        w_be      = 4'b0001 << r_lane;
        w_wr_data = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be      = r_lane[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_commit = (r_state == WAIT) && (r_cnt == 4'd1);

  // NOTE: the storage array has no reset; reset only forces the FSM to IDLE, which drops a pending store.
  always_ff @(posedge clk_i) begin
    if (w_commit && r_wr && !r_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_err       <= 1'b0;
      r_funct3    <= '0;
      r_idx       <= '0;
      r_lane      <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_i && r_req_ready) begin
            r_wr        <= req_wr_i;
            r_err       <= w_req_err;
            r_funct3    <= req_funct3_i;
            r_idx       <= req_addr_i[AddressWidth+1:2];
            r_lane      <= req_addr_i[1:0];
            r_wdata     <= req_wdata_i;
            r_cnt       <= 4'(Latency);
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            r_rsp_rdata <= (r_wr || r_err) ? '0 : w_load;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed RV32I cases plus randomized traffic
// checked against a byte-addressed reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v1 = 1'b0, v4 = 1'b0;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;

  logic        rdy1, val1, err1, rdy4, val4, err4;
  logic [31:0] rd1, rd4;

  logic        sel4 = 1'b0;
  logic        obs_ready, obs_valid, obs_err;
  logic [31:0] obs_rdata;

  int total = 0;
  int bad   = 0;

  bit [7:0] mb [int unsigned];

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } vec_t;

  always #5 clk = ~clk;

  dmem_responder #(.AddressWidth(10), .DataWidth(32), .Latency(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v1), .req_ready_o(rdy1),
    .req_wr_i(req_wr), .req_addr_i(req_addr), .req_funct3_i(req_funct3),
    .req_wdata_i(req_wdata), .rsp_valid_o(val1), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rd1), .rsp_err_o(err1));

  dmem_responder #(.AddressWidth(10), .DataWidth(32), .Latency(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v4), .req_ready_o(rdy4),
    .req_wr_i(req_wr), .req_addr_i(req_addr), .req_funct3_i(req_funct3),
    .req_wdata_i(req_wdata), .rsp_valid_o(val4), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rd4), .rsp_err_o(err4));

  always_comb begin
    obs_ready = sel4 ? rdy4 : rdy1;
    obs_valid = sel4 ? val4 : val1;
    obs_err   = sel4 ? err4 : err1;
    obs_rdata = sel4 ? rd4  : rd1;
  end

  // Reference: byte-addressed little-endian memory, 4 KiB span for 10 word-address bits.
  function automatic void model_access(input bit wr, input logic [31:0] a, input logic [2:0] f3,
                                       input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int unsigned nb;
    bit          bad_f3;
    logic [31:0] v;
    nb     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad_f3 = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    err    = bad_f3 || (a % nb != 0) || (a >= 32'h1000);
    rd     = '0;
    if (err) return;
    if (wr) begin
      for (int unsigned i = 0; i < nb; i++) mb[a + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int unsigned i = 0; i < nb; i++) v = v | (32'(mb[a + i]) << (8 * i));
      if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      rd = v;
    end
  endfunction

  task automatic txn(input bit use4, input bit wr, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, output logic [31:0] rd, output logic e,
                     output int lat, output bit ok);
    int n;
    bit done;
    rd = '0; e = 1'b0; lat = 0; ok = 1'b0; done = 1'b0;
    sel4 = use4;
    @(negedge clk);
    req_wr = wr; req_addr = a; req_funct3 = f3; req_wdata = wd; rsp_ready = 1'b1;
    if (use4) v4 = 1'b1; else v1 = 1'b1;
    n = 0;
    while (!obs_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!obs_ready) begin
      v1 = 1'b0; v4 = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0; v4 = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (obs_valid) begin
        rd = obs_rdata; e = obs_err; done = 1'b1;
      end
      @(posedge clk);
      lat++;
      if (!done) @(negedge clk);
    end
    ok = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", rdy1); end
    total++; if (val1 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", val1); end
    total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rd1); end
    total++; if (err1 !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err1); end
    total++; if (rdy4 !== 1'b1 || val4 !== 1'b0) begin
      bad++; $display("FAIL reset_dut4: ready=%b valid=%b want 1/0", rdy4, val4);
    end
  endtask

  task automatic test_word();
    vec_t vt [2] = '{
      '{1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, 32'h10, 3'd2, 32'h0,        32'hDEADBEEF, 1'b0}};
    logic [31:0] rd, mrd; logic e; bit merr; int lat; bit ok;
    foreach (vt[i]) begin
      model_access(vt[i].wr, vt[i].a, vt[i].f3, vt[i].wd, mrd, merr);
      txn(1'b0, vt[i].wr, vt[i].a, vt[i].f3, vt[i].wd, rd, e, lat, ok);
      total++; if (!ok) begin bad++; $display("FAIL word_timeout[%0d]: no response", i); end
      total++; if (rd !== vt[i].rd || e !== vt[i].err) begin
        bad++; $display("FAIL word[%0d]: got %h/%b want %h/%b", i, rd, e, vt[i].rd, vt[i].err);
      end
      total++; if (lat !== 2) begin bad++; $display("FAIL word_latency[%0d]: got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_subword();
    vec_t vt [6] = '{
      '{1'b1, 32'h11, 3'd0, 32'h123456AA, 32'h0,        1'b0},
      '{1'b0, 32'h10, 3'd2, 32'h0,        32'hDEADAAEF, 1'b0},
      '{1'b0, 32'h11, 3'd0, 32'h0,        32'hFFFFFFAA, 1'b0},
      '{1'b0, 32'h11, 3'd4, 32'h0,        32'h000000AA, 1'b0},
      '{1'b0, 32'h12, 3'd1, 32'h0,        32'hFFFFDEAD, 1'b0},
      '{1'b0, 32'h12, 3'd5, 32'h0,        32'h0000DEAD, 1'b0}};
    logic [31:0] rd, mrd; logic e; bit merr; int lat; bit ok;
    foreach (vt[i]) begin
      model_access(vt[i].wr, vt[i].a, vt[i].f3, vt[i].wd, mrd, merr);
      txn(1'b0, vt[i].wr, vt[i].a, vt[i].f3, vt[i].wd, rd, e, lat, ok);
      total++; if (!ok || rd !== vt[i].rd || e !== vt[i].err) begin
        bad++; $display("FAIL subword[%0d]: got %h/%b want %h/%b ok=%b", i, rd, e, vt[i].rd, vt[i].err, ok);
      end
    end
  endtask

  task automatic test_errors();
    vec_t vt [10] = '{
      '{1'b0, 32'h12,  3'd2, 32'h0,        32'h0,        1'b1},
      '{1'b1, 32'h13,  3'd1, 32'hFFFF,     32'h0,        1'b1},
      '{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEADAAEF, 1'b0},
      '{1'b0, 32'h1000,3'd2, 32'h0,        32'h0,        1'b1},
      '{1'b0, 32'h10,  3'd3, 32'h0,        32'h0,        1'b1},
      '{1'b0, 32'h10,  3'd7, 32'h0,        32'h0,        1'b1},
      '{1'b1, 32'h10,  3'd5, 32'h11111111, 32'h0,        1'b1},
      '{1'b0, 32'h10,  3'd2, 32'h0,        32'hDEADAAEF, 1'b0},
      '{1'b1, 32'hFFC, 3'd2, 32'h0BADF00D, 32'h0,        1'b0},
      '{1'b0, 32'hFFC, 3'd2, 32'h0,        32'h0BADF00D, 1'b0}};
    logic [31:0] rd, mrd; logic e; bit merr; int lat; bit ok;
    foreach (vt[i]) begin
      model_access(vt[i].wr, vt[i].a, vt[i].f3, vt[i].wd, mrd, merr);
      txn(1'b0, vt[i].wr, vt[i].a, vt[i].f3, vt[i].wd, rd, e, lat, ok);
      total++; if (!ok || rd !== vt[i].rd || e !== vt[i].err || lat !== 2) begin
        bad++; $display("FAIL error_case[%0d]: got %h/%b lat=%0d want %h/%b lat=2",
                        i, rd, e, lat, vt[i].rd, vt[i].err);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    sel4 = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0; v1 = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk) v1 = 1'b0;
    n = 0;
    while (!val1 && n < 20) begin @(negedge clk); n++; end
    total++; if (!val1) begin bad++; $display("FAIL bp_valid: got %b want 1", val1); end
    for (int c = 0; c < 5; c++) begin
      total++; if (val1 !== 1'b1 || rd1 !== 32'hDEADAAEF || err1 !== 1'b0 || rdy1 !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b ready=%b want 1/deadaaef/0/0",
                        c, val1, rd1, err1, rdy1);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (val1 !== 1'b0 || rdy1 !== 1'b1) begin
      bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", val1, rdy1);
    end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    sel4 = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    v1 = 1'b1; req_wr = 1'b0; req_addr = 32'h10; req_funct3 = 3'd2;
    for (int c = 0; c < 14; c++) begin
      if (rdy1) acc.push_back(c);
      @(negedge clk);
    end
    v1 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (acc.size() !== 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", acc.size()); end
    for (int i = 1; i < acc.size(); i++) begin
      total++; if (acc[i] - acc[i-1] !== 3) begin
        bad++; $display("FAIL b2b_gap[%0d]: got %0d want 3", i, acc[i] - acc[i-1]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, a, wd; logic e; bit merr, wr; logic [2:0] f3; int lat; bit ok;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      model_access(1'b1, 32'h100 + 32'(4*w), 3'd2, wd, mrd, merr);
      txn(1'b0, 1'b1, 32'h100 + 32'(4*w), 3'd2, wd, rd, e, lat, ok);
    end
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(1, 0));
      f3 = 3'($urandom_range(7, 0));
      wd = $urandom;
      a  = 32'h100 + 32'($urandom_range(63, 0));
      if ($urandom_range(7, 0) == 0) a = a | (32'd1 << $urandom_range(31, 12));
      model_access(wr, a, f3, wd, mrd, merr);
      txn(1'b0, wr, a, f3, wd, rd, e, lat, ok);
      total++; if (!ok || rd !== mrd || e !== merr || lat !== 2) begin
        bad++; $display("FAIL random[%0d] wr=%b a=%h f3=%0d: got %h/%b lat=%0d want %h/%b lat=2",
                        t, wr, a, f3, rd, e, lat, mrd, merr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat; bit ok;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    txn(1'b1, 1'b1, 32'h20, 3'd2, 32'h0, rd, e, lat, ok);
    total++; if (!ok || e !== 1'b0 || lat !== 5) begin
      bad++; $display("FAIL mid_prewrite: ok=%b err=%b lat=%0d want 1/0/5", ok, e, lat);
    end
    sel4 = 1'b1;
    @(negedge clk);
    v4 = 1'b1; req_wr = 1'b1; req_addr = 32'h20; req_funct3 = 3'd2; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk) v4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (val4 !== 1'b0 || rdy4 !== 1'b1) begin
      bad++; $display("FAIL mid_reset: valid=%b ready=%b want 0/1", val4, rdy4);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    txn(1'b1, 1'b0, 32'h20, 3'd2, 32'h0, rd, e, lat, ok);
    total++; if (!ok || rd !== 32'h0 || e !== 1'b0) begin
      bad++; $display("FAIL mid_dropped: got %h/%b ok=%b want 00000000/0", rd, e, ok);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
